// File: rtl/bram_param_loader.sv
// bram_param_loader
// Loads COUNT consecutive W-bit words from an external single-port BRAM,
// starting at a runtime base address, into a flat output vector. Word i
// lands in data_out[i*W +: W]. The BRAM read port is driven from registers
// so the loader can sit behind an arbiter shared with other clients.
//
// Capture timing is tracked by a READ_LATENCY-deep valid shift register
// that is loaded alongside every issued address, so the design adapts to
// any BRAM read latency without counter offset arithmetic.
//
// Optional feature: define LOADER_CHECKSUM_EN to add a checksum output
// holding the unsigned sum of all words captured by the current load.
module bram_param_loader #(
    parameter int W            = 8,
    parameter int COUNT        = 8,
    parameter int ADDR_WIDTH   = 18,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  busy,
    output logic                  done,
    output logic [COUNT*W-1:0]    data_out,
    output logic                  mem_en,
    output logic                  mem_ren,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [W-1:0]          mem_dout
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [W+$clog2(COUNT):0] checksum
`endif
);

    // Counters must be able to hold the value COUNT itself.
    localparam int            CW   = $clog2(COUNT + 1);
    localparam logic [CW-1:0] LAST = CW'(COUNT - 1);
    localparam logic [CW-1:0] FULL = CW'(COUNT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  state_q;
    logic                    busy_q;
    logic                    done_q;
    logic [COUNT*W-1:0]      data_q;
    logic                    en_q;
    logic                    ren_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [CW-1:0]           issue_cnt_q;
    logic [CW-1:0]           wptr_q;
    logic [READ_LATENCY-1:0] vld_q;

    logic                    ren_d;
    logic [READ_LATENCY-1:0] vld_d;
    logic                    capture;

`ifdef LOADER_CHECKSUM_EN
    localparam int SW = W + $clog2(COUNT) + 1;
    logic [SW-1:0] cks_q;
`endif

    // Next value of the read enable: an address is issued in the cycle after
    // an accepted start and in every ISSUE cycle until the last one is out.
    always_comb begin
        ren_d = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: ren_d = start;
            S_ISSUE:        ren_d = (issue_cnt_q != LAST);
            default:        ren_d = 1'b0;
        endcase
    end

    // Valid pipeline advances every cycle; its tail marks the edge on which
    // mem_dout carries the word for an address issued READ_LATENCY cycles ago.
    always_comb begin
        vld_d   = (vld_q << 1) | READ_LATENCY'(ren_d);
        capture = vld_q[READ_LATENCY-1] &&
                  ((state_q == S_ISSUE) || (state_q == S_DRAIN));
    end

    // Main control FSM with registered outputs, capture path included.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            data_q      <= '0;
            en_q        <= 1'b0;
            ren_q       <= 1'b0;
            addr_q      <= '0;
            issue_cnt_q <= '0;
            wptr_q      <= '0;
            vld_q       <= '0;
`ifdef LOADER_CHECKSUM_EN
            cks_q       <= '0;
`endif
        end else begin
            vld_q <= vld_d;
            ren_q <= ren_d;

            // Only the addressed slot is written; other slots keep old data.
            if (capture) begin
                for (int i = 0; i < COUNT; i++) begin
                    if (wptr_q == CW'(i)) begin
                        data_q[i*W +: W] <= mem_dout;
                    end
                end
                wptr_q <= wptr_q + CW'(1);
`ifdef LOADER_CHECKSUM_EN
                cks_q  <= cks_q + SW'(mem_dout);
`endif
            end

            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q     <= S_ISSUE;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        en_q        <= 1'b1;
                        addr_q      <= base_addr;
                        issue_cnt_q <= '0;
                        wptr_q      <= '0;
`ifdef LOADER_CHECKSUM_EN
                        cks_q       <= '0;
`endif
                    end
                end
                S_ISSUE: begin
                    if (issue_cnt_q == LAST) begin
                        state_q <= S_DRAIN;
                    end else begin
                        addr_q      <= addr_q + ADDR_WIDTH'(1);
                        issue_cnt_q <= issue_cnt_q + CW'(1);
                    end
                end
                S_DRAIN: begin
                    if (wptr_q == FULL) begin
                        en_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign data_out = data_q;
    assign mem_en   = en_q;
    assign mem_ren  = ren_q;
    assign mem_addr = addr_q;
`ifdef LOADER_CHECKSUM_EN
    assign checksum = cks_q;
`endif

endmodule

// File: tb/tb_bram_param_loader.sv
// tb_bram_param_loader
// Three loader instances in different configurations (COUNT=8/RL=2/AW=18,
// COUNT=1/RL=3, COUNT=4/AW=4), each backed by a BRAM model whose word is
// addr[7:0]. A table of loads is applied in a loop; expected data and the
// expected address sequence are queued when a load starts and compared as
// the DUT produces them.
module tb_bram_param_loader;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance 0: default configuration
    logic        start0, busy0, done0, en0, ren0;
    logic [17:0] base0, addr0, ap0;
    logic [63:0] data0;
    logic [7:0]  dout0;
    // Instance 1: COUNT=1, READ_LATENCY=3
    logic        start1, busy1, done1, en1, ren1;
    logic [17:0] base1, addr1, ap1a, ap1b;
    logic [7:0]  data1;
    logic [7:0]  dout1;
    // Instance 2: COUNT=4, ADDR_WIDTH=4
    logic        start2, busy2, done2, en2, ren2;
    logic [3:0]  base2, addr2, ap2;
    logic [31:0] data2;
    logic [7:0]  dout2;
`ifdef LOADER_CHECKSUM_EN
    logic [11:0] cks0;
    logic [8:0]  cks1;
    logic [10:0] cks2;
`endif

    bram_param_loader #(.W(8), .COUNT(8), .ADDR_WIDTH(18), .READ_LATENCY(2)) u0 (
        .clk(clk), .rst(rst), .start(start0), .base_addr(base0), .busy(busy0),
        .done(done0), .data_out(data0), .mem_en(en0), .mem_ren(ren0),
        .mem_addr(addr0), .mem_dout(dout0)
`ifdef LOADER_CHECKSUM_EN
        , .checksum(cks0)
`endif
    );

    bram_param_loader #(.W(8), .COUNT(1), .ADDR_WIDTH(18), .READ_LATENCY(3)) u1 (
        .clk(clk), .rst(rst), .start(start1), .base_addr(base1), .busy(busy1),
        .done(done1), .data_out(data1), .mem_en(en1), .mem_ren(ren1),
        .mem_addr(addr1), .mem_dout(dout1)
`ifdef LOADER_CHECKSUM_EN
        , .checksum(cks1)
`endif
    );

    bram_param_loader #(.W(8), .COUNT(4), .ADDR_WIDTH(4), .READ_LATENCY(2)) u2 (
        .clk(clk), .rst(rst), .start(start2), .base_addr(base2), .busy(busy2),
        .done(done2), .data_out(data2), .mem_en(en2), .mem_ren(ren2),
        .mem_addr(addr2), .mem_dout(dout2)
`ifdef LOADER_CHECKSUM_EN
        , .checksum(cks2)
`endif
    );

    // BRAM models: the word for an address appears READ_LATENCY edges later.
    always @(posedge clk) begin
        ap0  <= addr0;
        ap1a <= addr1;
        ap1b <= ap1a;
        ap2  <= addr2;
    end
    assign dout0 = ap0[7:0];
    assign dout1 = ap1b[7:0];
    assign dout2 = {4'b0, ap2};

    // Per-instance configuration and signal selection
    function automatic int cnt_of(int s);
        case (s)
            0:       return 8;
            1:       return 1;
            default: return 4;
        endcase
    endfunction

    function automatic logic g_done(int s);
        case (s)
            0:       return done0;
            1:       return done1;
            default: return done2;
        endcase
    endfunction

    function automatic logic g_busy(int s);
        case (s)
            0:       return busy0;
            1:       return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic logic g_en(int s);
        case (s)
            0:       return en0;
            1:       return en1;
            default: return en2;
        endcase
    endfunction

    function automatic logic g_ren(int s);
        case (s)
            0:       return ren0;
            1:       return ren1;
            default: return ren2;
        endcase
    endfunction

    function automatic logic [63:0] g_data(int s);
        case (s)
            0:       return data0;
            1:       return 64'(data1);
            default: return 64'(data2);
        endcase
    endfunction

    function automatic logic [17:0] g_addr(int s);
        case (s)
            0:       return addr0;
            1:       return addr1;
            default: return 18'(addr2);
        endcase
    endfunction

    task automatic set_start(input int s, input logic v, input logic [17:0] b);
        case (s)
            0:       begin start0 = v; base0 = b;      end
            1:       begin start1 = v; base1 = b;      end
            default: begin start2 = v; base2 = b[3:0]; end
        endcase
    endtask

    // Address issued for word i, wrapped to the instance's address width.
    function automatic logic [17:0] word_addr(int s, logic [17:0] base, int i);
        logic [17:0] a;
        a = base + 18'(i);
        if (s == 2) a[17:4] = '0;
        return a;
    endfunction

    function automatic logic [63:0] model(int s, logic [17:0] base);
        logic [63:0] r;
        logic [17:0] a;
        r = '0;
        for (int i = 0; i < cnt_of(s); i++) begin
            a = word_addr(s, base, i);
            r[i*8 +: 8] = a[7:0];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, want);
        end
    endtask

    // Scoreboard state
    logic [63:0] exp_q[$];
    logic [17:0] addr_q[$];
    logic [63:0] last_exp[3];
    int          act     = 0;
    int          ren_cnt = 0;

    // Address monitor: every cycle with mem_ren high must present the next
    // expected address.
    always @(negedge clk) begin
        if (!rst && g_ren(act)) begin
            ren_cnt++;
            if (addr_q.size() == 0) begin
                check("addr_extra", 64'(g_addr(act)), 64'hFFFF_FFFF);
            end else begin
                check("mem_addr", 64'(g_addr(act)), 64'(addr_q.pop_front()));
            end
        end
    end

    // One full load on instance s. poke_at/rst_at (cycles after accept)
    // inject a start pulse mid-load or a reset; negative disables.
    task automatic run_load(input int s, input logic [17:0] base, input logic [63:0] exp,
                            input int lat, input int poke_at, input int rst_at);
        int          n;
        logic [11:0] sum;
        exp_q.push_back(exp);
        for (int i = 0; i < cnt_of(s); i++) addr_q.push_back(word_addr(s, base, i));
        act     = s;
        ren_cnt = 0;
        @(negedge clk);
        set_start(s, 1'b1, base);
        @(negedge clk);
        set_start(s, 1'b0, base ^ 18'h15);
        check("busy_after_start", 64'(g_busy(s)), 64'd1);
        check("done_drops", 64'(g_done(s)), 64'd0);
        check("data_held", g_data(s), last_exp[s]);
`ifdef LOADER_CHECKSUM_EN
        if (s == 0) check("checksum_clear", 64'(cks0), 64'd0);
`endif
        n = 0;
        while (!g_done(s) && n < 50) begin
            @(negedge clk);
            n++;
            if (n == poke_at) set_start(s, 1'b1, 18'h2AAAA);
            else if (n == poke_at + 1) set_start(s, 1'b0, 18'h0);
            if (n == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("rst_busy", 64'(g_busy(s)), 64'd0);
                check("rst_done", 64'(g_done(s)), 64'd0);
                check("rst_data", g_data(s), 64'd0);
                check("rst_en", 64'(g_en(s)), 64'd0);
                check("rst_ren", 64'(g_ren(s)), 64'd0);
                check("rst_addr", 64'(g_addr(s)), 64'd0);
                exp_q.delete();
                addr_q.delete();
                for (int k = 0; k < 3; k++) last_exp[k] = '0;
                return;
            end
        end
        set_start(s, 1'b0, 18'h0);
        check("done_latency", 64'(n), 64'(lat));
        check("busy_at_done", 64'(g_busy(s)), 64'd0);
        check("en_at_done", 64'(g_en(s)), 64'd0);
        check("ren_cycles", 64'(ren_cnt), 64'(cnt_of(s)));
        check("addr_left", 64'(addr_q.size()), 64'd0);
        if (exp_q.size() == 0) check("data_queue_empty", 64'd1, 64'd0);
        else                   check("data_out", g_data(s), exp_q.pop_front());
`ifdef LOADER_CHECKSUM_EN
        if (s == 0) begin
            sum = '0;
            for (int i = 0; i < 8; i++) sum = sum + 12'(exp[i*8 +: 8]);
            check("checksum", 64'(cks0), 64'(sum));
        end
`endif
        last_exp[s] = exp;
    endtask

    typedef struct {
        int          s;
        logic [17:0] base;
        logic [63:0] exp;
        int          lat;
        int          poke_at;
        int          rst_at;
        int          gap;
    } vec_t;

    vec_t tbl[10];

    initial begin
        rst    = 1'b1;
        start0 = 1'b0; base0 = '0;
        start1 = 1'b0; base1 = '0;
        start2 = 1'b0; base2 = '0;
        for (int k = 0; k < 3; k++) last_exp[k] = '0;

        // s, base, expected data_out, done latency, poke, rst, extra gap
        tbl[0] = '{0, 18'd147504, 64'h3736_3534_3332_3130, 10, -1, -1, 0};
        tbl[1] = '{0, 18'd147504, 64'h3736_3534_3332_3130, 10,  2, -1, 0};
        tbl[2] = '{0, 18'd0,      64'h0706_0504_0302_0100, 10, -1, -1, 1};
        tbl[3] = '{0, 18'd262141, 64'h0403_0201_00FF_FEFD, 10, -1, -1, 0};
        tbl[4] = '{0, 18'd1000,   64'h0,                   10, -1,  3, 0};
        tbl[5] = '{0, 18'd147504, 64'h3736_3534_3332_3130, 10, -1, -1, 2};
        tbl[6] = '{1, 18'd5,      64'h05,                   4, -1, -1, 0};
        tbl[7] = '{2, 18'd14,     64'h0100_0F0E,            6, -1, -1, 0};
        tbl[8].s = 0; tbl[8].base = 18'($urandom_range(0, 262143));
        tbl[8].exp = model(0, tbl[8].base);
        tbl[8].lat = 10; tbl[8].poke_at = -1; tbl[8].rst_at = -1; tbl[8].gap = 0;
        tbl[9].s = 2; tbl[9].base = 18'($urandom_range(0, 15));
        tbl[9].exp = model(2, tbl[9].base);
        tbl[9].lat = 6; tbl[9].poke_at = -1; tbl[9].rst_at = -1; tbl[9].gap = 0;

        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy0), 64'd0);
        check("reset_done", 64'(done0), 64'd0);
        check("reset_data", data0, 64'd0);
        check("reset_en", 64'(en0), 64'd0);
        check("reset_ren", 64'(ren0), 64'd0);
        check("reset_addr", 64'(addr0), 64'd0);
        check("reset_data_u2", 64'(data2), 64'd0);
`ifdef LOADER_CHECKSUM_EN
        check("reset_checksum", 64'(cks0), 64'd0);
`endif
        rst = 1'b0;

        for (int k = 0; k < 10; k++) begin
            repeat (tbl[k].gap) @(negedge clk);
            run_load(tbl[k].s, tbl[k].base, tbl[k].exp, tbl[k].lat,
                     tbl[k].poke_at, tbl[k].rst_at);
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
